// File: rtl/acl2_spi_sequencer.sv
// ADXL362 burst sequencer driving the FIFO side of simple_spi_top_modified.
// Owns chip select, pushes instruction/address/payload bytes one at a time and streams read payload out.
`timescale 1ns/1ps
module acl2_spi_sequencer #(
  parameter int         LEN_W    = 8,
  parameter int         CS_SETUP = 4,   // must be >= 2
  parameter int         CS_HOLD  = 4,
  parameter int         TIMEOUT  = 1023,
  parameter logic [7:0] RD_CMD   = 8'h0B,
  parameter logic [7:0] WR_CMD   = 8'h0A
) (
  input  logic             clk_i,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rd,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ncs_o,
  input  logic [7:0]       spsr,
  input  logic [7:0]       rfdout,
  output logic             wfwe,
  output logic [7:0]       wfdin,
  output logic             rfre
);

  localparam int CNT_W = 16;
  localparam logic [LEN_W:0] IDX_PAYLOAD = (LEN_W+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_RX = 3'd3,
    S_POP     = 3'd4,
    S_DELIVER = 3'd5,
    S_NEXT    = 3'd6,
    S_HOLD    = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [LEN_W:0]   idx_r, idx_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic             rd_r, rd_s;
  logic [7:0]       addr_r, addr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             abort_r, abort_s;
  logic             ncs_r, ncs_s;
  logic             wfwe_r, wfwe_s;
  logic [7:0]       wfdin_r, wfdin_s;
  logic             rfre_r, rfre_s;
  logic [7:0]       rd_data_r, rd_data_s;
  logic             rd_valid_r, rd_valid_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic             busy_r, busy_s;
  logic             wr_ready_r, wr_ready_s;
  logic [7:0]       hdr_byte_s;
  logic             rx_empty_s;
  logic             unused_spsr_s;

  assign rx_empty_s    = spsr[0];
  assign unused_spsr_s = ^{spsr[7:1]};

  assign cmd_ready = (state_r == S_IDLE);
  assign ncs_o     = ncs_r;
  assign wfwe      = wfwe_r;
  assign wfdin     = wfdin_r;
  assign rfre      = rfre_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign done      = done_r;
  assign err       = err_r;
  assign busy      = busy_r;
  assign wr_ready  = wr_ready_r;

  // Byte for non-payload slots and read dummy bytes.
  always_comb begin
    hdr_byte_s = 8'h00;
    if (idx_r == (LEN_W+1)'(0)) begin
      hdr_byte_s = rd_r ? RD_CMD : WR_CMD;
    end else if (idx_r == (LEN_W+1)'(1)) begin
      hdr_byte_s = addr_r;
    end else begin
      hdr_byte_s = 8'h00;
    end
  end

  // Next-state and next-output logic of the burst FSM.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    len_s      = len_r;
    rd_s       = rd_r;
    addr_s     = addr_r;
    cnt_s      = cnt_r;
    abort_s    = abort_r;
    ncs_s      = ncs_r;
    wfwe_s     = 1'b0;
    wfdin_s    = wfdin_r;
    rfre_s     = 1'b0;
    rd_data_s  = rd_data_r;
    rd_valid_s = rd_valid_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    busy_s     = busy_r;
    wr_ready_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          rd_s    = cmd_rd;
          addr_s  = cmd_addr;
          len_s   = cmd_len;
          idx_s   = '0;
          cnt_s   = '0;
          abort_s = 1'b0;
          ncs_s   = 1'b0;
          busy_s  = 1'b1;
          state_s = S_SETUP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETUP: begin
        cnt_s = cnt_r + CNT_W'(1);
        // rfre is registered, so spsr is only trusted when no pop is still in flight
        if (!rx_empty_s && !rfre_r) begin
          rfre_s = 1'b1;
        end else begin
          rfre_s = 1'b0;
        end
        if ((cnt_r >= CNT_W'(CS_SETUP - 2)) && !rfre_r && rx_empty_s) begin
          cnt_s   = '0;
          state_s = S_SEND;
        end else begin
          state_s = S_SETUP;
        end
      end
      S_SEND: begin
        cnt_s = '0;
        if ((idx_r < IDX_PAYLOAD) || rd_r) begin
          wfwe_s  = 1'b1;
          wfdin_s = hdr_byte_s;
          state_s = S_WAIT_RX;
        end else if (wr_valid) begin
          wfwe_s     = 1'b1;
          wr_ready_s = 1'b1;
          wfdin_s    = wr_data;
          state_s    = S_WAIT_RX;
        end else begin
          state_s = S_SEND;
        end
      end
      S_WAIT_RX: begin
        if (!rx_empty_s) begin
          state_s = S_POP;
        end else if (cnt_r >= CNT_W'(TIMEOUT)) begin
          abort_s = 1'b1;
          cnt_s   = '0;
          state_s = S_HOLD;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_POP: begin
        rfre_s = 1'b1;
        if (rd_r && (idx_r >= IDX_PAYLOAD)) begin
          rd_data_s  = rfdout;
          rd_valid_s = 1'b1;
          state_s    = S_DELIVER;
        end else begin
          state_s = S_NEXT;
        end
      end
      S_DELIVER: begin
        if (rd_valid_r && rd_ready) begin
          rd_valid_s = 1'b0;
          state_s    = S_NEXT;
        end else begin
          state_s = S_DELIVER;
        end
      end
      S_NEXT: begin
        idx_s = idx_r + (LEN_W+1)'(1);
        if ((idx_r + (LEN_W+1)'(1)) == ({1'b0, len_r} + IDX_PAYLOAD)) begin
          cnt_s   = '0;
          state_s = S_HOLD;
        end else begin
          state_s = S_SEND;
        end
      end
      S_HOLD: begin
        if (cnt_r >= CNT_W'(CS_HOLD - 1)) begin
          ncs_s   = 1'b1;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          err_s   = abort_r;
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        ncs_s   = 1'b1;
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset parks the bus with chip select released.
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      state_r    <= S_IDLE;
      idx_r      <= '0;
      len_r      <= '0;
      rd_r       <= 1'b0;
      addr_r     <= 8'h00;
      cnt_r      <= '0;
      abort_r    <= 1'b0;
      ncs_r      <= 1'b1;
      wfwe_r     <= 1'b0;
      wfdin_r    <= 8'h00;
      rfre_r     <= 1'b0;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      wr_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      len_r      <= len_s;
      rd_r       <= rd_s;
      addr_r     <= addr_s;
      cnt_r      <= cnt_s;
      abort_r    <= abort_s;
      ncs_r      <= ncs_s;
      wfwe_r     <= wfwe_s;
      wfdin_r    <= wfdin_s;
      rfre_r     <= rfre_s;
      rd_data_r  <= rd_data_s;
      rd_valid_r <= rd_valid_s;
      done_r     <= done_s;
      err_r      <= err_s;
      busy_r     <= busy_s;
      wr_ready_r <= wr_ready_s;
    end
  end

endmodule

// File: tb/tb_acl2_spi_sequencer.sv
// Scoreboard bench for acl2_spi_sequencer with a behavioural SPI core / ADXL362 model on the FIFO side.
`timescale 1ns/1ps
module tb_acl2_spi_sequencer;

  logic       clk_i = 1'b0;
  logic       nrst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rd = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_len = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       busy, done, err, ncs_o, wfwe, rfre;
  logic [7:0] spsr = 8'h05;
  logic [7:0] rfdout = 8'h00;
  logic [7:0] wfdin;

  acl2_spi_sequencer dut (
    .clk_i(clk_i), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err), .ncs_o(ncs_o),
    .spsr(spsr), .rfdout(rfdout), .wfwe(wfwe), .wfdin(wfdin), .rfre(rfre)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  logic [7:0] rx_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_q[$];
  logic [7:0] pend_byte = 8'h00;
  int pend_cnt = -1;
  int byte_idx = 0;
  int drop_idx = -1;
  int tx_count = 0, rfre_count = 0, done_count = 0, err_count = 0, rd_count = 0;
  int ncs_falls = 0, mid_rise = 0;
  int rd_stall = 0, rd_wait = 0;
  int cyc = 0, last_wfwe_cyc = 0, done_cyc = 0;
  logic ncs_prev = 1'b1;

  // SPI core + slave model, write-data source, read consumer and monitors, all on the inactive edge.
  always @(negedge clk_i) begin
    cyc++;
    if (!nrst) begin
      rx_q.delete();
      pend_cnt = -1;
      byte_idx = 0;
    end else begin
      if (rfre) begin
        rfre_count++;
        if (rx_q.size() == 0) check_eq("rfre_on_empty", 1, 0);
        else void'(rx_q.pop_front());
      end
      if (pend_cnt > 0) pend_cnt--;
      else if (pend_cnt == 0) begin
        rx_q.push_back(pend_byte);
        pend_cnt = -1;
      end
      if (wfwe) begin
        tx_count++;
        last_wfwe_cyc = cyc;
        check_eq("ncs_low_at_wfwe", ncs_o, 0);
        if (exp_tx.size() == 0) check_eq("wfwe_extra", 1, 0);
        else check_eq("wfdin", wfdin, exp_tx.pop_front());
        if (byte_idx != drop_idx) begin
          if (byte_idx < 2) pend_byte = 8'hEE;
          else if (resp_q.size() > 0) pend_byte = resp_q.pop_front();
          else pend_byte = 8'h00;
          pend_cnt = 6;
        end
        byte_idx++;
      end
      if (ncs_o) byte_idx = 0;
      if (done) begin
        done_count++;
        done_cyc = cyc;
        if (err) err_count++;
      end
      if (err && !done) check_eq("err_without_done", 1, 0);
      if (!ncs_prev && ncs_o && !done) mid_rise++;
    end
    if (ncs_prev && !ncs_o) ncs_falls++;
    ncs_prev = ncs_o;
    spsr   = {5'd0, 1'b1, 1'b0, (rx_q.size() == 0)};
    rfdout = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    if (wr_ready) begin
      if (wr_q.size() > 0) void'(wr_q.pop_front());
      else check_eq("wr_ready_extra", 1, 0);
    end
    wr_valid = (wr_q.size() > 0);
    wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    if (rd_valid) begin
      rd_ready = (rd_wait >= rd_stall);
      rd_wait++;
      if (rd_ready) begin
        rd_count++;
        rd_wait = 0;
        if (exp_rd.size() == 0) check_eq("rd_extra", 1, 0);
        else check_eq("rd_data", rd_data, exp_rd.pop_front());
      end
    end else begin
      rd_ready = 1'b0;
      rd_wait  = 0;
    end
  end

  task automatic run_burst(input logic rd, input logic [7:0] addr, input logic [7:0] len, input int budget);
    int start;
    start = done_count;
    @(negedge clk_i); #1;
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_rd = rd; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk_i); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < budget && done_count == start; i++) begin
      @(negedge clk_i); #1;
    end
    check_eq("burst_done", done_count - start, 1);
  endtask

  int b_rfre, b_tx, b_done, b_err, b_rd, b_falls;
  logic [7:0] rd6 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  task automatic snap();
    b_rfre = rfre_count; b_tx = tx_count; b_done = done_count;
    b_err = err_count; b_rd = rd_count; b_falls = ncs_falls;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    check_eq("rst_ncs", ncs_o, 1);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_outs", {done, err, wfwe, rfre, rd_valid, wr_ready}, 0);
    check_eq("rst_data", {wfdin, rd_data}, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk_i);

    // write 0x02 to 0x2D; payload offered early must be ignored during header
    snap();
    wr_q.push_back(8'h02);
    exp_tx.push_back(8'h0A); exp_tx.push_back(8'h2D); exp_tx.push_back(8'h02);
    run_burst(1'b0, 8'h2D, 8'd1, 2000);
    check_eq("wr_tx_cnt", tx_count - b_tx, 3);
    check_eq("wr_rfre_cnt", rfre_count - b_rfre, 3);
    check_eq("wr_err", err_count - b_err, 0);
    check_eq("wr_ncs_falls", ncs_falls - b_falls, 1);
    check_eq("wr_payload_used", wr_q.size(), 0);
    check_eq("wr_ncs_high", ncs_o, 1);

    // read 1 byte from 0x00
    snap();
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    resp_q.push_back(8'hAD); exp_rd.push_back(8'hAD);
    run_burst(1'b1, 8'h00, 8'd1, 2000);
    check_eq("rd1_count", rd_count - b_rd, 1);
    check_eq("rd1_rfre_cnt", rfre_count - b_rfre, 3);
    check_eq("rd1_err", err_count - b_err, 0);

    // 6-byte read with a slow consumer and a stray request while busy
    snap();
    rd_stall = 20;
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'h0E);
    for (int i = 0; i < 6; i++) begin
      exp_tx.push_back(8'h00); resp_q.push_back(rd6[i]); exp_rd.push_back(rd6[i]);
    end
    fork
      run_burst(1'b1, 8'h0E, 8'd6, 3000);
      begin
        repeat (40) @(negedge clk_i);
        #1 cmd_valid = 1'b1;
        repeat (5) @(negedge clk_i);
        #1 cmd_valid = 1'b0;
      end
    join
    rd_stall = 0;
    repeat (10) @(negedge clk_i);
    #1;
    check_eq("rd6_count", rd_count - b_rd, 6);
    check_eq("rd6_ncs_falls", ncs_falls - b_falls, 1);
    check_eq("rd6_single_done", done_count - b_done, 1);
    check_eq("rd6_tx_cnt", tx_count - b_tx, 8);

    // slave never answers payload byte -> timeout abort
    snap();
    drop_idx = 2;
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'h08); exp_tx.push_back(8'h00);
    run_burst(1'b1, 8'h08, 8'd2, 4000);
    check_eq("to_err", err_count - b_err, 1);
    check_eq("to_wait_long", (done_cyc - last_wfwe_cyc) >= 1023, 1);
    check_eq("to_tx_cnt", tx_count - b_tx, 3);
    check_eq("to_rfre_cnt", rfre_count - b_rfre, 2);
    check_eq("to_ncs_high", ncs_o, 1);
    check_eq("to_no_rd", rd_count - b_rd, 0);
    drop_idx = -1;
    snap();
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'h0E); exp_tx.push_back(8'h00);
    resp_q.push_back(8'h5A); exp_rd.push_back(8'h5A);
    run_burst(1'b1, 8'h0E, 8'd1, 2000);
    check_eq("after_to_err", err_count - b_err, 0);
    check_eq("after_to_rd", rd_count - b_rd, 1);

    // two stale RX bytes drained during setup
    snap();
    @(negedge clk_i); #1;
    rx_q.push_back(8'h99); rx_q.push_back(8'h98);
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'h0F); exp_tx.push_back(8'h00);
    resp_q.push_back(8'h3C); exp_rd.push_back(8'h3C);
    run_burst(1'b1, 8'h0F, 8'd1, 2000);
    check_eq("stale_rfre_cnt", rfre_count - b_rfre, 5);
    check_eq("stale_rd", rd_count - b_rd, 1);

    // reset in the middle of a 4-byte read
    snap();
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(8'h00); resp_q.push_back(8'hC0 + 8'(i)); exp_rd.push_back(8'hC0 + 8'(i));
    end
    @(negedge clk_i); #1;
    cmd_rd = 1'b1; cmd_addr = 8'h00; cmd_len = 8'd4; cmd_valid = 1'b1;
    @(negedge clk_i); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 400 && tx_count < b_tx + 3; i++) begin
      @(negedge clk_i); #1;
    end
    check_eq("rst_mid_reached", tx_count - b_tx, 3);
    nrst = 1'b0;
    @(negedge clk_i); #1;
    check_eq("rst_mid_ncs", ncs_o, 1);
    check_eq("rst_mid_cmd_ready", cmd_ready, 1);
    check_eq("rst_mid_rd_valid", rd_valid, 0);
    nrst = 1'b1;
    exp_tx.delete(); exp_rd.delete(); resp_q.delete();
    repeat (20) @(negedge clk_i);
    #1;
    check_eq("rst_mid_no_done", done_count - b_done, 0);
    check_eq("rst_mid_no_rd", rd_count - b_rd, 0);
    check_eq("rst_mid_idle", {busy, ncs_o, cmd_ready}, 3'b011);

    check_eq("ncs_mid_rise", mid_rise, 0);
    check_eq("tx_left", exp_tx.size(), 0);
    check_eq("rd_left", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
